// File: rtl/dpd_pkg.sv
// dpd_pkg: shared definitions for the DPD feedback-path blocks.
// Holds the clog2 helper, the delay estimator FSM states and the
// accumulator width rule (2W product bits plus clog2(N) growth bits).
package dpd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEARCH  = 2'd2,
    DONE    = 2'd3
  } de_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Width that holds a sum of n full-precision w x w products without overflow.
  function automatic int acc_w(input int w, input int n);
    return 2 * w + clog2(n);
  endfunction

endpackage

// File: rtl/delay_est_if.sv
// delay_est_if: request/sample/result bundle of the coarse delay estimator.
// master = the controller feeding samples, slave = delay_est.
interface delay_est_if #(
  parameter int W = 16,
  parameter int N = 64,
  parameter int L = 32
);
  import dpd_pkg::*;

  localparam int ACC_W = acc_w(W, N);
  localparam int LAG_W = clog2(L);

  logic                    start;
  logic                    valid_in;
  logic signed [W-1:0]     ref_in;
  logic signed [W-1:0]     fb_in;
  logic                    busy;
  logic                    done;
  logic [LAG_W-1:0]        lag_out;
  logic signed [ACC_W-1:0] peak_out;

  modport master (
    output start, valid_in, ref_in, fb_in,
    input  busy, done, lag_out, peak_out
  );

  modport slave (
    input  start, valid_in, ref_in, fb_in,
    output busy, done, lag_out, peak_out
  );

endinterface

// File: rtl/delay_est_mac.sv
// delay_est_mac: registered signed multiplier followed by an accumulator.
// Two cycles from operands to acc_o. first_i restarts the sum with the
// current product; last_i travels with the data and pulses last_o in the
// cycle where acc_o holds a completed sum.
module delay_est_mac #(
  parameter int W     = 16,
  parameter int ACC_W = 38
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    vld_i,
  input  logic                    first_i,
  input  logic                    last_i,
  input  logic signed [W-1:0]     a_i,
  input  logic signed [W-1:0]     b_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    last_o
);
  localparam int PW = 2 * W;

  logic signed [PW-1:0]    prod_d;
  logic signed [PW-1:0]    prod_q;
  logic                    p_vld_q;
  logic                    p_first_q;
  logic                    p_last_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;
  logic                    last_q;

  // full-precision product of the sign-extended operands
  always_comb begin
    prod_d = PW'(a_i) * PW'(b_i);
  end

  // first product of a lag replaces the running sum instead of adding to it
  always_comb begin
    acc_d = p_first_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
  end

  // product register, then accumulator register; flags follow the data
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      prod_q    <= '0;
      p_vld_q   <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      acc_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      p_vld_q   <= vld_i;
      p_first_q <= vld_i & first_i;
      p_last_q  <= vld_i & last_i;
      if (vld_i) begin
        prod_q <= prod_d;
      end
      if (p_vld_q) begin
        acc_q <= acc_d;
      end
      last_q <= p_last_q;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = last_q;

endmodule

// File: rtl/delay_est.sv
// delay_est: coarse delay estimator for the DPD feedback path.
// Captures N reference and N+L-1 feedback samples, then correlates them
// serially (one product per cycle) for lags 0..L-1 and reports the lag with
// the largest correlation. Earliest lag wins ties.
// Build option: define DELAY_EST_ABS_EN to rank lags by |acc| instead of the
// signed acc, so a 180-degree inverted feedback path is still found.
module delay_est
  import dpd_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 64,
  parameter int L = 32
) (
  input logic        clk,
  input logic        reset_b,
  delay_est_if.slave de
);
  localparam int ACC_W  = acc_w(W, N);
  localparam int LAG_W  = clog2(L);
  localparam int NB     = clog2(N);
  localparam int FB_D   = N + L - 1;
  localparam int CW     = clog2(FB_D);
  localparam int SW     = clog2(L * N + 3);

  de_state_e               state_q;
  de_state_e               state_d;
  logic                    busy_c;
  logic                    done_c;

  logic [CW-1:0]           cap_cnt_q;
  logic [SW-1:0]           srch_cnt_q;
  logic                    start_acc;
  logic                    cap_we;
  logic                    cap_last;
  logic                    srch_end;
  logic                    issue;

  logic signed [W-1:0]     ref_mem [N];
  logic signed [W-1:0]     fb_mem  [FB_D];
  logic [NB-1:0]           n_idx;
  logic [LAG_W-1:0]        l_idx;
  logic [CW-1:0]           fb_raddr;
  logic signed [W-1:0]     ref_rd_q;
  logic signed [W-1:0]     fb_rd_q;
  logic                    rd_vld_q;
  logic                    rd_first_q;
  logic                    rd_last_q;

  logic signed [ACC_W-1:0] mac_acc;
  logic                    mac_last;
  logic signed [ACC_W-1:0] metric;
  logic                    take;
  logic signed [ACC_W-1:0] best_d;
  logic signed [ACC_W-1:0] best_q;
  logic [LAG_W-1:0]        best_lag_d;
  logic [LAG_W-1:0]        best_lag_q;
  logic [LAG_W-1:0]        cmp_lag_q;
  logic [LAG_W-1:0]        lag_out_q;
  logic signed [ACC_W-1:0] peak_out_q;

  assign start_acc = (state_q == IDLE) && de.start;
  assign cap_we    = (state_q == CAPTURE) && de.valid_in;
  assign cap_last  = cap_we && (cap_cnt_q == CW'(FB_D - 1));
  assign srch_end  = (state_q == SEARCH) && (srch_cnt_q == SW'(L * N + 2));
  assign issue     = (state_q == SEARCH) && (srch_cnt_q < SW'(L * N));

  // state register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (de.start) state_d = CAPTURE;
      CAPTURE: if (cap_last) state_d = SEARCH;
      SEARCH:  if (srch_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      CAPTURE, SEARCH: busy_c = 1'b1;
      DONE:            done_c = 1'b1;
      default:         ;
    endcase
  end

  // capture sample index and search step counter, both cleared by a new start
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cap_cnt_q  <= '0;
      srch_cnt_q <= '0;
    end else if (start_acc) begin
      cap_cnt_q  <= '0;
      srch_cnt_q <= '0;
    end else begin
      if (cap_we) begin
        cap_cnt_q <= cap_cnt_q + 1'b1;
      end
      if (state_q == SEARCH) begin
        srch_cnt_q <= srch_cnt_q + 1'b1;
      end
    end
  end

  // reference write port: only the first N captured samples are kept
  always_ff @(posedge clk) begin
    if (cap_we && (cap_cnt_q < CW'(N))) begin
      ref_mem[cap_cnt_q[NB-1:0]] <= de.ref_in;
    end
  end

  // feedback write port: all N+L-1 captured samples
  always_ff @(posedge clk) begin
    if (cap_we) begin
      fb_mem[cap_cnt_q] <= de.fb_in;
    end
  end

  // search counter splits into sample index (low bits) and lag (high bits)
  assign n_idx    = srch_cnt_q[NB-1:0];
  assign l_idx    = srch_cnt_q[NB+LAG_W-1:NB];
  assign fb_raddr = CW'(n_idx) + CW'(l_idx);

  // registered read ports of both sample memories
  always_ff @(posedge clk) begin
    ref_rd_q <= ref_mem[n_idx];
    fb_rd_q  <= fb_mem[fb_raddr];
  end

  // issue flags aligned with the memory read data
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_vld_q   <= issue;
      rd_first_q <= (n_idx == '0);
      rd_last_q  <= (n_idx == NB'(N - 1));
    end
  end

  delay_est_mac #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset_b (reset_b),
    .vld_i   (rd_vld_q),
    .first_i (rd_first_q),
    .last_i  (rd_last_q),
    .a_i     (ref_rd_q),
    .b_i     (fb_rd_q),
    .acc_o   (mac_acc),
    .last_o  (mac_last)
  );

  // ranking metric for a completed lag sum
  always_comb begin
`ifdef DELAY_EST_ABS_EN
    metric = (mac_acc < 0) ? -mac_acc : mac_acc;
`else
    metric = mac_acc;
`endif
  end

  // lag 0 always seeds the peak; later lags must be strictly greater
  always_comb begin
    take       = mac_last && ((cmp_lag_q == '0) || (metric > best_q));
    best_d     = take ? metric : best_q;
    best_lag_d = take ? cmp_lag_q : best_lag_q;
  end

  // running peak, and result registers loaded as the final lag is ranked
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cmp_lag_q  <= '0;
      best_q     <= '0;
      best_lag_q <= '0;
      lag_out_q  <= '0;
      peak_out_q <= '0;
    end else begin
      best_q     <= best_d;
      best_lag_q <= best_lag_d;
      if (start_acc) begin
        cmp_lag_q <= '0;
      end else if (mac_last) begin
        cmp_lag_q <= cmp_lag_q + 1'b1;
      end
      if (mac_last && (cmp_lag_q == LAG_W'(L - 1))) begin
        lag_out_q  <= best_lag_d;
        peak_out_q <= best_d;
      end
    end
  end

  assign de.busy     = busy_c;
  assign de.done     = done_c;
  assign de.lag_out  = lag_out_q;
  assign de.peak_out = peak_out_q;

endmodule
